// File: rtl/reg_port_if.sv
// Shared register-address port bundle: requester-side signals and the arbiter's
// grant/mux outputs for a 4-way round-robin arbiter.
interface reg_port_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [3:0]        req;
  logic [3:0]        rel;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              valid;
  logic [ADDR_W-1:0] addr_out;
  logic              timeout_err;

  modport master (
    output req, rel, addr0, addr1, addr2, addr3,
    input  gnt, sel, valid, addr_out, timeout_err
  );

  modport slave (
    input  req, rel, addr0, addr1, addr2, addr3,
    output gnt, sel, valid, addr_out, timeout_err
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter for one shared register-address port among four requesters,
// with a bounded hold time per grant and a pulse on forced (timeout) releases.
module reg_port_arbiter #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic       clk,
  input logic       reset,
  reg_port_if.slave bus
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t      state;
  logic [1:0]  last;
  logic [7:0]  cnt;
  logic [3:0]  gnt_q;
  logic [1:0]  sel_q;
  logic        valid_q;
  logic        terr_q;

  logic [1:0]  win;
  logic [1:0]  cand;
  logic        found;

  logic        own_rel;
  logic        own_req;
  logic        at_limit;

  logic [ADDR_W-1:0] addr_mux;

  // Scan last+1 .. last+4 (mod 4); the previous winner is considered last.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_rel  = bus.rel[sel_q];
    own_req  = bus.req[sel_q];
    at_limit = (cnt == 8'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 2'd3;
      cnt     <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state   <= OWNED;
            gnt_q   <= 4'b0001 << win;
            sel_q   <= win;
            valid_q <= 1'b1;
            last    <= win;
            cnt     <= 8'd1;
          end
        end
        OWNED: begin
          if (own_rel || !own_req || at_limit) begin
            state   <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt     <= '0;
            // A voluntary release on the limit cycle is not a forced release.
            terr_q  <= at_limit && !own_rel && own_req;
          end else if (!at_limit) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    addr_mux = bus.addr0;
      2'd1:    addr_mux = bus.addr1;
      2'd2:    addr_mux = bus.addr2;
      default: addr_mux = bus.addr3;
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.valid       = valid_q;
  assign bus.timeout_err = terr_q;
  assign bus.addr_out    = valid_q ? addr_mux : '0;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: a per-edge reference model queues the
// expected outputs and a negedge monitor compares them against the DUT.
module tb_reg_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int TMO = 15;

  logic clk;
  logic reset;

  reg_port_if #(.ADDR_W(AW)) bus ();

  reg_port_arbiter #(
    .ADDR_W (AW),
    .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: owner index or -1 when the port is free.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 3;
  bit m_err   = 0;

  always @(posedge clk) begin
    exp_t e;
    logic [3:0] r;
    logic [3:0] rl;
    r  = bus.req;
    rl = bus.rel;
    m_err = 0;
    if (reset) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && r[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      if (rl[m_owner] || !r[m_owner]) begin
        m_owner = -1;
      end else if (m_held == TMO) begin
        m_owner = -1;
        m_err   = 1;
      end else begin
        m_held++;
      end
    end
    e.valid = (m_owner >= 0);
    e.gnt   = e.valid ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = e.valid ? 2'(m_owner) : 2'd0;
    e.err   = m_err;
    q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [1:0] i);
    case (i)
      2'd0:    return bus.addr0;
      2'd1:    return bus.addr1;
      2'd2:    return bus.addr2;
      default: return bus.addr3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt",         32'(bus.gnt),         32'(e.gnt));
      chk("sel",         32'(bus.sel),         32'(e.sel));
      chk("valid",       32'(bus.valid),       32'(e.valid));
      chk("timeout_err", 32'(bus.timeout_err), 32'(e.err));
      chk("addr_out",    32'(bus.addr_out),    e.valid ? 32'(addr_of(e.sel)) : 32'd0);
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] rl, input int n);
    bus.req = r;
    bus.rel = rl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_addr();
    bus.addr0 = AW'($urandom);
    bus.addr1 = AW'($urandom);
    bus.addr2 = AW'($urandom);
    bus.addr3 = AW'($urandom);
  endtask

  initial begin
    reset     = 1'b1;
    bus.req   = '0;
    bus.rel   = '0;
    bus.addr0 = 4'hA;
    bus.addr1 = 4'h5;
    bus.addr2 = 4'hC;
    bus.addr3 = 4'h3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single grant then release by strobe.
    step(4'b0001, 4'b0000, 2);
    step(4'b0001, 4'b0001, 1);
    step(4'b0000, 4'b0000, 2);

    // Fairness: all request, owner releases two cycles into each grant.
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 4'b0000, 2);
      step(4'b1111, 4'b1111, 1);
      step(4'b1111, 4'b0000, 1);
    end
    step(4'b0000, 4'b0000, 2);

    // Timeout with a held sole request, then re-grant.
    step(4'b0100, 4'b0000, 20);
    step(4'b0000, 4'b0000, 3);

    // Release strobe on the limit cycle, non-owner release strobes mid-grant.
    step(4'b0100, 4'b0000, 1);
    step(4'b0100, 4'b1011, 5);
    step(4'b0100, 4'b0000, 9);
    step(4'b0100, 4'b0100, 1);
    step(4'b0000, 4'b0000, 2);

    // Owner 1 drops its request while 3 waits.
    step(4'b0010, 4'b0000, 3);
    step(4'b1010, 4'b0000, 2);
    step(4'b1000, 4'b0000, 3);
    step(4'b0000, 4'b0000, 2);

    // Reset mid-grant, then 0 must win over 2.
    step(4'b0100, 4'b0000, 7);
    reset = 1'b1;
    step(4'b0101, 4'b0000, 1);
    reset = 1'b0;
    step(4'b0101, 4'b0000, 4);
    step(4'b0000, 4'b0000, 2);

    // Randomized phases: busy with strobes, or long holds that reach the limit.
    for (int ph = 0; ph < 60; ph++) begin
      bit         hold;
      logic [3:0] r;
      hold = ($urandom_range(0, 3) == 0);
      r    = 4'($urandom);
      for (int c = 0; c < 30; c++) begin
        logic [3:0] rl;
        rand_addr();
        if (!hold && $urandom_range(0, 3) == 0) r = 4'($urandom);
        rl = '0;
        for (int b = 0; b < 4; b++)
          if (!hold && $urandom_range(0, 5) == 0) rl[b] = 1'b1;
        reset = ($urandom_range(0, 150) == 0);
        step(r, rl, 1);
      end
    end
    reset = 1'b0;
    step(4'b0000, 4'b0000, 3);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
